// File: rtl/retrieve_stream.sv
// Read side of a circular buffer: registered one-word-per-cycle reads with
// optional peek, flush to the producer pointer, and an underflow pulse.
module retrieve_stream #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    outstrobe,
  input  logic                    peek,
  input  logic                    flush,
  input  logic [ADDR_W:0]         wr_ptr,
  input  logic [WIDTH*DEPTH-1:0]  buffer,
  output logic [WIDTH-1:0]        rxda,
  output logic                    rxvalid,
  output logic                    underflow,
  output logic [ADDR_W:0]         rd_ptr,
  output logic [ADDR_W:0]         level,
  output logic                    empty
);

  // Handshake: outstrobe is a request with no back-pressure; when it is
  // granted, rxda/rxvalid appear exactly one cycle later and rxvalid is a
  // single-cycle qualifier. A refused request (empty) yields underflow instead.

  logic [WIDTH-1:0] words [DEPTH];
  logic             grant;
  logic             starved;
  logic [ADDR_W:0]  rd_ptr_next;

  for (genvar i = 0; i < DEPTH; i++) begin : g_words
    assign words[i] = buffer[i*WIDTH +: WIDTH];
  end

  // The wrap bit makes full (addresses equal, MSBs differ) distinct from empty.
  assign empty = (rd_ptr == wr_ptr);
  assign level = wr_ptr - rd_ptr;

  assign grant   = outstrobe & ~empty & ~flush;
  assign starved = outstrobe &  empty & ~flush;

  always_comb begin
    rd_ptr_next = rd_ptr;
    if (flush) begin
      rd_ptr_next = wr_ptr;
    end else if (grant && !peek) begin
      rd_ptr_next = rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr    <= '0;
      rxda      <= '0;
      rxvalid   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      rxvalid   <= grant;
      underflow <= starved;
      if (grant) begin
        rxda <= words[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: doc/retrieve_stream.md
RETRIEVE_STREAM -- requirements
Module: retrieve_stream

Interface
REQ-001 Parameter WIDTH, default 8: data bits per buffer word; legal range 1 to 32.
REQ-002 Parameter DEPTH, default 8: number of buffer words; power of two, at least 2.
REQ-003 Parameter ADDR_W, default 3: log2(DEPTH); the instantiator sets it consistently with DEPTH.
REQ-004 The block SHALL have one clock, clock, and a synchronous active-high reset, reset; no other clock or asynchronous input is used.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 outstrobe  in  1  read request; one word requested per high cycle.
REQ-008 peek  in  1  when high, a granted read does not advance the pointer.
REQ-009 flush  in  1  discards all unread words.
REQ-010 wr_ptr  in  ADDR_W+1  producer write pointer; the MSB is the wrap bit.
REQ-011 buffer  in  WIDTH*DEPTH  flattened storage; word i is buffer[i*WIDTH +: WIDTH].
REQ-012 rxda  out  WIDTH  registered read data.
REQ-013 rxvalid  out  1  one-cycle qualifier for rxda.
REQ-014 underflow  out  1  one-cycle pulse on a read request while empty.
REQ-015 rd_ptr  out  ADDR_W+1  registered read pointer; the MSB is the wrap bit.
REQ-016 level  out  ADDR_W+1  unread word count.
REQ-017 empty  out  1  high when no unread word exists.

Function
REQ-018 empty SHALL be combinational: rd_ptr == wr_ptr, comparing all ADDR_W+1 bits.
REQ-019 level SHALL be combinational: (wr_ptr - rd_ptr) modulo 2^(ADDR_W+1); the range is 0..DEPTH.
REQ-020 A read is granted in a cycle when outstrobe=1, empty=0 and flush=0.
REQ-021 On a granted read, rxda SHALL load buffer word rd_ptr[ADDR_W-1:0] at the clock edge, and rxvalid SHALL be 1 for the following cycle only.
REQ-022 Read latency is exactly one cycle, from the outstrobe sample edge to rxda/rxvalid; back-to-back grants SHALL yield one word per cycle.
REQ-023 On a granted read with peek=0, rd_ptr SHALL increment by 1 modulo 2^(ADDR_W+1); the address wraps from DEPTH-1 to 0 and the MSB toggles.
REQ-024 On a granted read with peek=1, rd_ptr SHALL stay unchanged, and repeated peeks SHALL return the same word.
REQ-025 When outstrobe=1, empty=1 and flush=0, underflow SHALL pulse for one cycle; rxvalid=0, and rxda and rd_ptr are unchanged.
REQ-026 When flush=1, rd_ptr SHALL load wr_ptr at the edge; rxvalid=0 and underflow=0 regardless of outstrobe or peek, so flush has priority.
REQ-027 rxda SHALL hold its last value while rxvalid=0.
REQ-028 Only rd_ptr, rxda, rxvalid and underflow SHALL be registered; buffer and wr_ptr changes in the grant cycle affect the word sampled at that edge.
REQ-029 A full buffer (level=DEPTH, addresses equal, MSBs differ) SHALL read normally, and empty SHALL be 0.
REQ-030 The block SHALL never write buffer or wr_ptr.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set rd_ptr=0, rxda=0, rxvalid=0 and underflow=0; reset overrides flush and outstrobe.
REQ-032 Reset asserted mid-stream SHALL cancel any pending rxvalid on the next cycle; no partial word is emitted.

Verification (WIDTH=8, DEPTH=4, ADDR_W=2)
REQ-033 Basic read: reset, then word i = 0xA0+i and wr_ptr=3; outstrobe high for 3 cycles -> rxda = 0xA0, 0xA1, 0xA2 on consecutive cycles with rxvalid=1, rd_ptr=3, empty=1.
REQ-034 Wrap: wr_ptr stepped to 7 while reading continuously -> rd_ptr passes 3 to 4 (address 0, MSB=1), data order is 0xA3, 0xA0, 0xA1, 0xA2, and final level=0.
REQ-035 Full and underflow: rd_ptr=0, wr_ptr=4 -> level=4 and empty=0; 4 reads then one more outstrobe -> 4 valid words, then underflow=1 for one cycle with rxvalid=0 and rxda still 0xA3.
REQ-036 Peek: rd_ptr=1, wr_ptr=3, peek=1, outstrobe for 2 cycles -> rxda=0xA1 twice and rd_ptr stays 1; peek=0 then one read -> 0xA1 and rd_ptr=2.
REQ-037 Flush versus read: rd_ptr=0, wr_ptr=3, flush=1 with outstrobe=1 -> rxvalid=0, underflow=0, rd_ptr=3, empty=1.
REQ-038 Reset mid-read: reset asserted in the same cycle as a granted read -> next cycle rxvalid=0, rxda=0, rd_ptr=0.
